digit_register_reader: RTL and testbench

Read side of the calculator digit register. On a start request it snapshots the packed NUM_DIGITS x DIGIT_W digit word and streams the digits out one at a time, most significant first, over a valid/ready handshake. The consumer is the display character renderer. Each digit is tagged with its index, a last flag and an optional leading-zero blank flag.

---
 rtl/digit_register_reader.sv | 154 +++++++++++++++
 tb/tb_digit_register_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_register_reader.sv
// digit_register_reader
//   Read side of the calculator digit register. A start request snapshots the
//   packed digit word, then the digits are streamed most significant first
//   over a valid/ready handshake to the display character renderer.
//
//   Handshake: a digit moves on every rising clock edge where dig_valid and
//   dig_ready are both 1. While dig_valid=1 and dig_ready=0, every dig_*
//   output is held unchanged. dig_ready has no effect while dig_valid=0.
//
//   Ports
//     clock, reset   rising-edge clock, synchronous active-high reset
//     start          begin a scan (only honoured in IDLE, and only if abort=0)
//     abort          end the current scan at once; no done pulse
//     A              packed digits, digit i = A[i*DIGIT_W +: DIGIT_W]
//     dig_valid      a digit is presented
//     dig_ready      consumer accepts the presented digit
//     dig_value      presented digit value
//     dig_index      presented digit position, NUM_DIGITS-1 down to 0
//     dig_blank      presented digit is a suppressed leading zero
//     dig_last       presented digit is digit 0
//     busy           scan in progress (SCAN or DONE)
//     done           one-cycle pulse after digit 0 has been transferred
//     dbg_state_o    current FSM state (0 IDLE, 1 SCAN, 2 DONE)
//
//   Build option
//     LEADING_ZERO_BLANK_EN  defined: dig_blank flags leading zeros.
//                            undefined: dig_blank is tied to 0 and the
//                            seen-nonzero tracking is not built.
module digit_register_reader #(
  parameter int NUM_DIGITS = 10,
  parameter int DIGIT_W    = 4,
  parameter int IDX_W      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] A,
  output logic                          dig_valid,
  input  logic                          dig_ready,
  output logic [DIGIT_W-1:0]            dig_value,
  output logic [IDX_W-1:0]              dig_index,
  output logic                          dig_blank,
  output logic                          dig_last,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_DIGITS*DIGIT_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [DIGIT_W-1:0]              cur_value;

  // Select the snapshot digit addressed by the current index.
  always_comb begin
    cur_value = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_value = snap_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_q, seen_d;
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
`ifdef LEADING_ZERO_BLANK_EN
    seen_d  = seen_q;
`endif
    case (state_q)
      S_IDLE: begin
        // abort beats start: a simultaneous request starts nothing.
        if (start && !abort) begin
          state_d = S_SCAN;
          snap_d  = A;
          idx_d   = IDX_W'(NUM_DIGITS - 1);
`ifdef LEADING_ZERO_BLANK_EN
          seen_d  = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (dig_ready) begin
          // dig_valid is 1 throughout SCAN, so dig_ready alone marks a transfer.
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
`ifdef LEADING_ZERO_BLANK_EN
          seen_d = seen_q | (cur_value != '0);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      seen_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
`ifdef LEADING_ZERO_BLANK_EN
      seen_q  <= seen_d;
`endif
    end
  end

  // Every digit output is decoded from registers only, so it stays put
  // while the consumer stalls.
  assign dig_valid   = (state_q == S_SCAN);
  assign dig_value   = cur_value;
  assign dig_index   = idx_q;
  assign dig_last    = dig_valid && (idx_q == '0);
  assign busy        = (state_q != S_IDLE);
  // abort raised during the DONE cycle cancels the pending pulse.
  assign done        = (state_q == S_DONE) && !abort;
  assign dbg_state_o = state_q;

`ifdef LEADING_ZERO_BLANK_EN
  // Digit 0 is never blanked so an all-zero word still shows one "0".
  assign dig_blank = dig_valid && (cur_value == '0) && !seen_q && (idx_q != '0);
`else
  assign dig_blank = 1'b0;
`endif

endmodule

// File: tb/tb_digit_register_reader.sv
module tb_digit_register_reader;

  localparam int NUM_DIGITS = 10;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 4;
  localparam int AW         = NUM_DIGITS * DIGIT_W;
  localparam int EW         = IDX_W + DIGIT_W + 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic               clock;
  logic               reset;
  logic               start;
  logic               abort;
  logic [AW-1:0]      A;
  logic               dig_valid;
  logic               dig_ready;
  logic [DIGIT_W-1:0] dig_value;
  logic [IDX_W-1:0]   dig_index;
  logic               dig_blank;
  logic               dig_last;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected digits, packed as {index, value, blank, last}.
  logic [EW-1:0] exp_q[$];

  digit_register_reader #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIGIT_W(DIGIT_W),
    .IDX_W(IDX_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .A(A),
    .dig_valid(dig_valid),
    .dig_ready(dig_ready),
    .dig_value(dig_value),
    .dig_index(dig_index),
    .dig_blank(dig_blank),
    .dig_last(dig_last),
    .busy(busy),
    .done(done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, dig_valid, 1'b0);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_done"},  done,      1'b0);
  endtask

  // Reference model: digits high to low; a zero is blank only while every
  // higher digit was zero, and digit 0 is never blank.
  task automatic build_expected(input logic [AW-1:0] a);
    bit nz_above;
    nz_above = 1'b0;
    exp_q.delete();
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      logic [DIGIT_W-1:0] v;
      logic               b;
      v = DIGIT_W'((a >> (i * DIGIT_W)) & 'hF);
      b = BLANK_EN && (v == 0) && !nz_above && (i != 0);
      if (v != 0) nz_above = 1'b1;
      exp_q.push_back({IDX_W'(i), v, b, (i == 0)});
    end
  endtask

  // ---------------- driver ----------------
  // ready_mode: 0 always ready, 1 toggle 0/1 starting at 0, 2 random.
  // stop_at: index at which to abort (or reset if use_reset); -1 for none.
  // poke: at index 7 zero A and pulse start. abort_done: abort in DONE.
  task automatic run_scan(input logic [AW-1:0] a, input int ready_mode,
                          input int stop_at, input bit use_reset,
                          input bit poke, input bit abort_done);
    int   cycles;
    bit   tog;
    logic r;
    logic [EW-1:0] e;
    A     = a;
    start = 1'b1;
    next_cycle();
    start  = 1'b0;
    build_expected(a);
    cycles = 0;
    tog    = 1'b0;
    while (exp_q.size() != 0) begin
      if (cycles >= 100) begin
        checks++;
        failures++;
        $display("FAIL scan_timeout observed=%0d_left expected=0_left", exp_q.size());
        exp_q.delete();
        dig_ready = 1'b0;
        return;
      end
      start = 1'b0;
      e = exp_q[0];
      check("scan_valid", dig_valid, 1'b1);
      check("scan_busy",  busy,      1'b1);
      check("scan_done",  done,      1'b0);
      check("scan_index", dig_index, e[EW-1 -: IDX_W]);
      check("scan_value", dig_value, e[DIGIT_W+1 -: DIGIT_W]);
      check("scan_blank", dig_blank, e[1]);
      check("scan_last",  dig_last,  e[0]);
      case (ready_mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      dig_ready = r;
      if (ready_mode == 2) A = {$urandom, $urandom};
      if (stop_at >= 0 && int'(e[EW-1 -: IDX_W]) == stop_at) begin
        if (use_reset) reset = 1'b1; else abort = 1'b1;
        next_cycle();
        reset = 1'b0;
        abort = 1'b0;
        dig_ready = 1'b0;
        check_idle("stop_next");
        if (use_reset) check("stop_reset_index", dig_index, 0);
        next_cycle();
        check_idle("stop_after");
        exp_q.delete();
        return;
      end
      if (poke && int'(e[EW-1 -: IDX_W]) == 7) begin
        A     = '0;
        start = 1'b1;
      end
      next_cycle();
      cycles++;
      if (r) void'(exp_q.pop_front());
    end
    start     = 1'b0;
    dig_ready = 1'b0;
    if (ready_mode == 0) check("scan_cycles_b2b", cycles, 10);
    if (ready_mode == 1) check("scan_cycles_bp",  cycles, 20);
    check("done_valid", dig_valid, 1'b0);
    check("done_busy",  busy,      1'b1);
    if (abort_done) begin
      abort = 1'b1;
      #1;
      check("abort_done_pulse", done, 1'b0);
      next_cycle();
      abort = 1'b0;
      check_idle("abort_done_after");
    end else begin
      check("done_pulse", done, 1'b1);
      next_cycle();
      check_idle("post_done");
    end
    next_cycle();
    check_idle("post_done2");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    abort     = 1'b0;
    dig_ready = 1'b0;
    A         = 40'h12_3456_7890;
    #1;
    // Reset held with start asserted: nothing may start.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check_idle("reset_hold");
      check("reset_index", dig_index, 0);
      check("reset_value", dig_value, 0);
      check("reset_state", dbg_state, 2'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    next_cycle();
    check_idle("after_reset");

    // abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_vs_start");

    // Back-to-back stream.
    run_scan(40'h00_0000_1234, 0, -1, 1'b0, 1'b0, 1'b0);
    // Backpressure.
    run_scan(40'h98_7654_3210, 1, -1, 1'b0, 1'b0, 1'b0);
    // All zero.
    run_scan(40'h00_0000_0000, 0, -1, 1'b0, 1'b0, 1'b0);
    // Snapshot held, start while busy ignored.
    run_scan(40'h11_1111_1111, 0, -1, 1'b0, 1'b1, 1'b0);
    // Abort at index 5, then full rescan.
    run_scan(40'h00_5060_7080, 0, 5, 1'b0, 1'b0, 1'b0);
    run_scan(40'h00_5060_7080, 0, -1, 1'b0, 1'b0, 1'b0);
    // Reset at index 5, then full rescan.
    run_scan(40'hA0_0B00_C00D, 0, 5, 1'b1, 1'b0, 1'b0);
    run_scan(40'hA0_0B00_C00D, 0, -1, 1'b0, 1'b0, 1'b0);
    // Abort during DONE suppresses the pulse.
    run_scan(40'h00_0000_0F00, 0, -1, 1'b0, 1'b0, 1'b1);

    // Random words (biased toward leading zeros) with random backpressure.
    for (int n = 0; n < 8; n++) begin
      logic [AW-1:0] a;
      int            lz;
      a  = {$urandom, $urandom};
      lz = $urandom_range(0, NUM_DIGITS);
      a  = (lz == NUM_DIGITS) ? '0 : (a & ({AW{1'b1}} >> (lz * DIGIT_W)));
      run_scan(a, 2, -1, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
